// File: rtl/npu_tile_sequencer_pkg.sv
// Shared widths and FSM encoding for the NPU tile sequencer.
// Widths are the global CLOG2 values used across the NPU array.
package npu_tile_sequencer_pkg;

  localparam int CLOG2T = 2;
  localparam int CLOG2B = 2;
  localparam int CLOG2C = 2;
  localparam int CLOG2W = 4;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_ISSUE,
    SEQ_WAIT,
    SEQ_DONE
  } npu_seq_state_t;

endpackage

// File: rtl/npu_loop_cnt.sv
// Wrapping loop counter; wrap flags the terminal value so that
// the next inc returns q to zero and carries into the outer loop.
module npu_loop_cnt
  import npu_tile_sequencer_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [N-1:0] last,
  output logic [N-1:0] q,
  output logic         wrap
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  assign wrap = (q_q == last);
  assign q    = q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = wrap ? '0 : q_q + N'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/npu_tile_sequencer.sv
// Per-layer (tile, ofmap, ifmap) loop sequencer issuing one NPU
// pass per triple with a start/done handshake.
module npu_tile_sequencer
  import npu_tile_sequencer_pkg::*;
#(
  parameter int TW = CLOG2T,
  parameter int BW = CLOG2B,
  parameter int CW = CLOG2C,
  parameter int GW = CLOG2W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              c1_c2_n,
  input  logic [TW-1:0]     arv_tile,
  input  logic [BW-1:0]     arv_ifmaps,
  input  logic [CW-1:0]     arv_ofmaps,
  input  logic [GW-1:0]     arv_ckgate,
  input  logic              npu_done,
  output logic              npu_start,
  output logic [TW-1:0]     tile_idx,
  output logic [CW-1:0]     ofmap_idx,
  output logic [BW-1:0]     ifmap_idx,
  output logic              acc_clear,
  output logic              acc_wb,
  output logic              cfg_c1_c2_n,
  output logic [GW-1:0]     cfg_ckgate,
  output logic              busy,
  output logic              layer_done,
  output logic [TW+CW+BW:0] pass_cnt
);

  // One extra bit so a full all-ones layer (2^(TW+CW+BW) passes) fits.
  localparam int PW = TW + CW + BW + 1;

  npu_seq_state_t state_q, state_d;

  logic          c1_q;
  logic [GW-1:0] gate_q;
  logic [TW-1:0] lt_q;
  logic [CW-1:0] lo_q;
  logic [BW-1:0] li_q;
  logic [PW-1:0] pcnt_q;

  logic launch, done_ok, all_last;
  logic i_inc, o_inc, t_inc;
  logic i_wrap, o_wrap, t_wrap;

  assign launch   = (state_q == SEQ_IDLE) && start;
  assign done_ok  = (state_q == SEQ_WAIT) && npu_done;
  assign all_last = i_wrap & o_wrap & t_wrap;
  assign i_inc    = done_ok & ~all_last;
  assign o_inc    = i_inc & i_wrap;
  assign t_inc    = o_inc & o_wrap;

  npu_loop_cnt #(.N(BW)) u_ifmap (
    .clk (clk),
    .rst (rst),
    .clr (launch),
    .inc (i_inc),
    .last(li_q),
    .q   (ifmap_idx),
    .wrap(i_wrap)
  );

  npu_loop_cnt #(.N(CW)) u_ofmap (
    .clk (clk),
    .rst (rst),
    .clr (launch),
    .inc (o_inc),
    .last(lo_q),
    .q   (ofmap_idx),
    .wrap(o_wrap)
  );

  npu_loop_cnt #(.N(TW)) u_tile (
    .clk (clk),
    .rst (rst),
    .clr (launch),
    .inc (t_inc),
    .last(lt_q),
    .q   (tile_idx),
    .wrap(t_wrap)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEQ_IDLE:  if (start) state_d = SEQ_ISSUE;
      SEQ_ISSUE: state_d = SEQ_WAIT;
      SEQ_WAIT: begin
        if (npu_done) begin
          state_d = all_last ? SEQ_DONE : SEQ_ISSUE;
        end
      end
      SEQ_DONE:  state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
      c1_q    <= 1'b0;
      gate_q  <= '0;
      lt_q    <= '0;
      lo_q    <= '0;
      li_q    <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        c1_q   <= c1_c2_n;
        gate_q <= arv_ckgate;
        lt_q   <= arv_tile;
        lo_q   <= arv_ofmaps;
        li_q   <= arv_ifmaps;
        pcnt_q <= '0;
      end else if (done_ok) begin
        pcnt_q <= pcnt_q + PW'(1);
      end
    end
  end

  assign npu_start   = (state_q == SEQ_ISSUE);
  assign acc_clear   = npu_start && (ifmap_idx == '0);
  assign acc_wb      = npu_start && (ifmap_idx == li_q);
  assign busy        = (state_q != SEQ_IDLE);
  assign layer_done  = (state_q == SEQ_DONE);
  assign cfg_c1_c2_n = c1_q;
  assign cfg_ckgate  = gate_q;
  assign pass_cnt    = pcnt_q;

endmodule
